ivl_uvm_ovl_rd_responder: RTL and testbench
===========================================

# ivl_uvm_ovl_rd_responder

Read-side responder for the rd / rd_ack / DATA window protocol checked by `ovl_win_change` in the OVL test suite. It accepts a read request on `rd`, returns a word from a small preloadable memory after a fixed latency, and pulses `rd_ack`. It drives the data bus so that it always changes at least once inside the rd-to-rd_ack window. It is the DUT side of the window-change tests, replacing hand-driven DATA/rd_ack stimulus in the benches.

## Interface
- `DATA_W`, default 8: width of the read data bus.
- `ADDR_W`, default 4: memory address width; depth is 2**ADDR_W words.
- `LATENCY`, default 1: cycles from request accept to `rd_ack`; legal range 1..15.
- `clk`  input  1  single clock; all logic on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `rd`  input  1  read request, level-sensitive; may be held high across transactions.
- `addr`  input  ADDR_W  read address, sampled at accept.
- `wr_en`  input  1  memory write strobe, for preload.
- `wr_addr`  input  ADDR_W  write address.
- `wr_data`  input  DATA_W  write data.
- `rd_ack`  output  1  one-cycle, registered read-complete pulse.
- `data`  output  DATA_W  registered read data bus.
- `busy`  output  1  high while a request is outstanding (WAIT state).
- `txn_cnt`  output  16  count of completed transactions; saturates at 16'hFFFF.

## Operation
- States:
  - IDLE: no request.
  - WAIT: request accepted, latency counting.
  - ACK: `rd_ack` high for this cycle.
- Accept condition: the state is IDLE or ACK and `rd`=1 at a rising edge. In ACK, this gives back-to-back requests.
- On accept, in the same edge:
  - latch `rdata_q <= mem[addr]`;
  - `data <= ~mem[addr]` (turnaround marker);
  - load latency counter with LATENCY-1;
  - go to WAIT.
- WAIT behaviour:
  - If the counter is 0: go to ACK, `rd_ack <= 1`, `data <= rdata_q`, and `txn_cnt` increments (saturating).
  - Otherwise: decrement the counter, and `data` holds.
- ACK behaviour:
  - `rd_ack <= 0` at the next edge.
  - Go to WAIT if accepting (`rd`=1), otherwise go to IDLE.
- IDLE: `data` holds its last value.
- Guaranteed data change: in the ack cycle `data` equals `rdata_q`; in the preceding cycle it equals `~rdata_q`. They differ for any value, so the window-change property always holds.
- `rd` deasserting during WAIT does not cancel the request; it completes normally.
- `addr` is ignored outside the accept edge.
- Memory writes:
  - Accepted in every state.
  - A write to the address of an in-flight read does not affect the returned word, which was latched at accept.
  - A write and a read-accept to the same address in the same cycle return the old word (read-before-write).
- Memory contents are not cleared by reset. A read of an unwritten word returns X in simulation; benches must preload.

## Timing
- Reset values, applied at the first edge with `reset`=1:
  - state = IDLE;
  - `rd_ack` = 0, `data` = 0, `busy` = 0, `txn_cnt` = 0;
  - latency counter = 0.
- Reset during WAIT or ACK aborts the transaction: no `rd_ack` is issued and `txn_cnt` is not incremented.
- `reset` has priority over accept and over write. No write occurs in a reset cycle.
- Latency: accept at edge k gives `rd_ack`=1 between edge k+LATENCY and edge k+LATENCY+1.
- `busy` is high from edge k to edge k+LATENCY, and is low in the ACK cycle.
- Throughput with `rd` held high is one transaction per LATENCY+1 cycles.
- With LATENCY=1 and `rd` held high, `rd_ack` toggles 0,1,0,1,… and `data` alternates between ~word and word.
- First accept possible: the first edge after `reset` falls.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset then idle: hold `reset`=1 for 5 clks, then `rd`=0 for 10 clks -> `rd_ack`=0, `data`=0, `busy`=0, `txn_cnt`=0 throughout.
- Single read, LATENCY=1:
  - Stimulus: preload mem[3]=8'hA5; pulse `rd`=1 for 1 clk with `addr`=3.
  - Response: the next cycle shows `data`=8'h5A and `busy`=1. The cycle after shows `data`=8'hA5 and `rd_ack`=1. Then `txn_cnt`=1 and the `ovl_win_change` instance reports no fire.
- Back-to-back, LATENCY=1:
  - Stimulus: mem[0]=8'h00, mem[1]=8'hFF; `rd` held high; `addr` alternates 0,1 at the accept edges.
  - Response: `rd_ack` pattern 0,1,0,1; `data` sequence FF,00,00,FF. After 4 transactions `txn_cnt`=4.
- LATENCY=4, with `rd` dropped after accept:
  - Stimulus: mem[7]=8'h3C; `rd`=1 for 1 clk with `addr`=7.
  - Response: `busy`=1 for 4 cycles with `data`=8'hC3, then `rd_ack`=1 with `data`=8'h3C on the 5th cycle. Exactly one ack.
- Write collision:
  - Stimulus: mem[2]=8'h11; accept a read of `addr`=2 while writing 8'h22 to address 2 in the same cycle; then read address 2 again.
  - Response: first read returns 8'h11, second read returns 8'h22.
- Reset mid-operation:
  - Stimulus: LATENCY=4; accept a read; assert `reset` at the 2nd WAIT cycle for 1 clk.
  - Response: no `rd_ack`, `data`=0, `txn_cnt` unchanged at 0. A new `rd` after reset completes normally.

Source files
------------

// File: rtl/ivl_uvm_ovl_rd_responder.sv
// ivl_uvm_ovl_rd_responder
// Read-side responder for the rd / rd_ack / DATA window protocol.
// A request on rd is accepted in IDLE or ACK. The word at addr is read from a
// small preloadable memory and returned after LATENCY cycles with a one-cycle
// rd_ack pulse. During the wait the bus shows the inverted word, so data is
// guaranteed to change inside every rd-to-rd_ack window.
module ivl_uvm_ovl_rd_responder #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 4,
    parameter int LATENCY = 1   // legal range 1..15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_ack,
    output logic [DATA_W-1:0] data,
    output logic              busy,
    output logic [15:0]       txn_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    // Counter load value: WAIT lasts LATENCY cycles, the last one with count 0.
    localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

    state_t            state;
    logic [3:0]        lat_cnt;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic              accept;

    // A new request can be taken whenever no read is in flight (IDLE or ACK).
    assign accept = rd && ((state == IDLE) || (state == ACK));

    // Preload write port; writes are suppressed in a reset cycle.
    // NOTE: the memory array has no reset -- clearing it would turn the RAM
    // into a register file; benches preload every word they intend to read.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Request FSM with registered outputs: accept, count latency, acknowledge.
    // NOTE: non-blocking assignments here and in the write port mean a read
    // accept and a write to the same address on one edge return the old word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            lat_cnt <= 4'd0;
            rdata_q <= '0;
            rd_ack  <= 1'b0;
            data    <= '0;
            busy    <= 1'b0;
            txn_cnt <= 16'd0;
        end else begin
            rd_ack <= 1'b0;
            case (state)
                WAIT: begin
                    if (lat_cnt == 4'd0) begin
                        state  <= ACK;
                        rd_ack <= 1'b1;
                        data   <= rdata_q;
                        busy   <= 1'b0;
                        if (txn_cnt != 16'hFFFF) begin
                            txn_cnt <= txn_cnt + 16'd1;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                default: begin
                    // IDLE and ACK behave alike: take a request or go quiet.
                    if (accept) begin
                        rdata_q <= mem[addr];
                        data    <= ~mem[addr];   // turnaround marker
                        lat_cnt <= LAT_LOAD;
                        busy    <= 1'b1;
                        state   <= WAIT;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ivl_uvm_ovl_rd_responder.sv
// Testbench for ivl_uvm_ovl_rd_responder.
// Two instances (LATENCY 1 and 4) share one stimulus stream. A transaction-
// level reference model predicts every output after every clock edge.
module tb_ivl_uvm_ovl_rd_responder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rd = 1'b0;
    logic [3:0] addr = '0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [7:0] wr_data = '0;

    logic        ack_w  [2];
    logic [7:0]  data_w [2];
    logic        busy_w [2];
    logic [15:0] cnt_w  [2];

    always #5 clk = ~clk;

    ivl_uvm_ovl_rd_responder #(.DATA_W(8), .ADDR_W(4), .LATENCY(1)) u_lat1 (
        .clk(clk), .reset(reset), .rd(rd), .addr(addr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_ack(ack_w[0]), .data(data_w[0]), .busy(busy_w[0]), .txn_cnt(cnt_w[0])
    );

    ivl_uvm_ovl_rd_responder #(.DATA_W(8), .ADDR_W(4), .LATENCY(4)) u_lat4 (
        .clk(clk), .reset(reset), .rd(rd), .addr(addr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_ack(ack_w[1]), .data(data_w[1]), .busy(busy_w[1]), .txn_cnt(cnt_w[1])
    );

    // ---------------- reference model ----------------
    // Each instance is described by "is a read outstanding, and at which edge
    // does it complete"; outputs follow from that and the returned word.
    int          n_checks = 0;
    int          n_pass   = 0;
    longint      cyc      = 0;
    int          lat      [2] = '{1, 4};
    bit          pend     [2] = '{0, 0};
    longint      ack_at   [2] = '{0, 0};
    logic [7:0]  word     [2] = '{8'h00, 8'h00};
    logic [7:0]  e_data   [2] = '{8'h00, 8'h00};
    bit          e_ack    [2] = '{0, 0};
    bit          e_busy   [2] = '{0, 0};
    int          e_cnt    [2] = '{0, 0};
    logic [7:0]  ref_mem  [16];

    function automatic void model_step();
        cyc++;
        for (int i = 0; i < 2; i++) begin
            e_ack[i] = 1'b0;
            if (reset) begin
                pend[i]   = 1'b0;
                e_data[i] = 8'h00;
                e_cnt[i]  = 0;
            end else if (pend[i] && cyc == ack_at[i]) begin
                e_ack[i]  = 1'b1;
                e_data[i] = word[i];
                pend[i]   = 1'b0;
                if (e_cnt[i] < 65535) e_cnt[i]++;
            end else if (!pend[i] && rd) begin
                word[i]   = ref_mem[addr];   // old contents: write applied below
                e_data[i] = ~word[i];
                pend[i]   = 1'b1;
                ack_at[i] = cyc + lat[i];
            end
            e_busy[i] = pend[i];
        end
        if (!reset && wr_en) ref_mem[wr_addr] = wr_data;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_model();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("c%0d_ack%0d", cyc, i),  32'(ack_w[i]),  32'(e_ack[i]));
            check($sformatf("c%0d_data%0d", cyc, i), 32'(data_w[i]), 32'(e_data[i]));
            check($sformatf("c%0d_busy%0d", cyc, i), 32'(busy_w[i]), 32'(e_busy[i]));
            check($sformatf("c%0d_cnt%0d", cyc, i),  32'(cnt_w[i]),  32'(e_cnt[i]));
        end
    endtask

    // One clock: inputs are already set (we sit at a falling edge).
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    task automatic idle(input int n);
        rd = 1'b0;
        wr_en = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    logic [7:0] b2b_data [4] = '{8'hFF, 8'h00, 8'h00, 8'hFF};
    logic [7:0] preload  [16];

    initial begin
        @(negedge clk);

        // Reset for 5 clocks, then idle for 10.
        reset = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b0;
        idle(10);
        check("idle_data0", 32'(data_w[0]), 32'h0);
        check("idle_cnt1",  32'(cnt_w[1]),  32'h0);

        // Preload every word so no read returns X.
        for (int i = 0; i < 16; i++) preload[i] = 8'($urandom);
        preload[0] = 8'h00; preload[1] = 8'hFF; preload[2] = 8'h11;
        preload[3] = 8'hA5; preload[7] = 8'h3C;
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_addr = 4'(i); wr_data = preload[i];
            tick();
        end
        wr_en = 1'b0;
        idle(2);

        // Single read of address 3.
        rd = 1'b1; addr = 4'd3;
        tick();
        rd = 1'b0;
        check("single_turn_data", 32'(data_w[0]), 32'h5A);
        check("single_turn_busy", 32'(busy_w[0]), 32'h1);
        tick();
        check("single_ack_data", 32'(data_w[0]), 32'hA5);
        check("single_ack",      32'(ack_w[0]),  32'h1);
        tick();
        check("single_cnt", 32'(cnt_w[0]), 32'h1);
        check("single_ack_low", 32'(ack_w[0]), 32'h0);
        idle(4);

        // LATENCY=4 read of address 7 with rd dropped after accept.
        rd = 1'b1; addr = 4'd7;
        tick();
        rd = 1'b0;
        for (int j = 0; j < 4; j++) begin
            check($sformatf("lat4_busy_%0d", j), 32'(busy_w[1]), 32'h1);
            check($sformatf("lat4_data_%0d", j), 32'(data_w[1]), 32'hC3);
            check($sformatf("lat4_noack_%0d", j), 32'(ack_w[1]), 32'h0);
            tick();
        end
        check("lat4_ack",      32'(ack_w[1]),  32'h1);
        check("lat4_ack_data", 32'(data_w[1]), 32'h3C);
        check("lat4_ack_busy", 32'(busy_w[1]), 32'h0);
        tick();
        check("lat4_one_ack", 32'(ack_w[1]), 32'h0);
        check("lat4_cnt",     32'(cnt_w[1]), 32'h2);
        idle(3);

        // Back-to-back with rd held high, addresses 0,1,0,1 at the accepts.
        rd = 1'b1;
        for (int t = 0; t < 8; t++) begin
            addr = 4'((t >> 1) & 1);
            tick();
            check($sformatf("b2b_ack_%0d", t),  32'(ack_w[0]),  32'(t & 1));
            check($sformatf("b2b_data_%0d", t), 32'(data_w[0]), 32'(b2b_data[t & 3]));
        end
        check("b2b_cnt", 32'(cnt_w[0]), 32'd6);
        idle(6);

        // Read-before-write collision on address 2, then a fresh read.
        rd = 1'b1; addr = 4'd2;
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 8'h22;
        tick();
        rd = 1'b0; wr_en = 1'b0;
        tick();
        check("coll_old_ack",  32'(ack_w[0]),  32'h1);
        check("coll_old_word", 32'(data_w[0]), 32'h11);
        idle(5);
        rd = 1'b1; addr = 4'd2;
        tick();
        rd = 1'b0;
        tick();
        check("coll_new_ack",  32'(ack_w[0]),  32'h1);
        check("coll_new_word", 32'(data_w[0]), 32'h22);
        idle(5);

        // Reset in the second WAIT cycle of the LATENCY=4 instance.
        rd = 1'b1; addr = 4'd5;
        tick();
        rd = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_ack",  32'(ack_w[1]),  32'h0);
        check("rst_mid_data", 32'(data_w[1]), 32'h0);
        check("rst_mid_busy", 32'(busy_w[1]), 32'h0);
        check("rst_mid_cnt",  32'(cnt_w[1]),  32'h0);
        idle(6);
        check("rst_mid_no_ack_cnt", 32'(cnt_w[1]), 32'h0);
        rd = 1'b1; addr = 4'd6;
        tick();
        rd = 1'b0;
        idle(5);
        check("rst_after_cnt", 32'(cnt_w[1]), 32'h1);

        // Randomized traffic with occasional writes and resets.
        for (int t = 0; t < 400; t++) begin
            rd      = ($urandom_range(0, 3) != 0);
            addr    = 4'($urandom);
            wr_en   = ($urandom_range(0, 2) == 0);
            wr_addr = 4'($urandom);
            wr_data = 8'($urandom);
            reset   = ($urandom_range(0, 49) == 0);
            tick();
        end
        reset = 1'b0;
        idle(6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
